eth_pcs_block_lock: RTL and testbench

// - Rx block-lock controller for the 10GBASE-R PCS (IEEE 802.3 cl.49 lock_state FSM).
// - Checks the 2-bit sync header of each 66b block from the Rx gearbox and drives the gearbox

---
 rtl/eth_pcs_params.sv | 23 ++
 rtl/eth_pcs_block_lock.sv | 120 ++++++++++++
 tb/tb_eth_pcs_block_lock.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_pcs_params.sv
// Shared 10GBASE-R PCS constants: sync header encodings, block-lock thresholds and FSM states.
package eth_pcs_params;

  localparam int W_SYNC = 2;
  localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;
  localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;

  localparam int N_SH_GOOD_DEF   = 64;
  localparam int N_SH_BAD_DEF    = 16;
  localparam int N_SLIP_WAIT_DEF = 2;

  typedef enum logic [1:0] {
    S_RESET_CNT,
    S_TEST,
    S_SLIP,
    S_WAIT
  } lock_state_t;

  function automatic logic sync_hdr_ok(input logic [W_SYNC-1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_pcs_block_lock.sv
// Rx block-lock FSM: tests 66b sync headers, requests gearbox slips until aligned, gates the decoder reset.
// Lock/dec_reset are registered one enabled cycle after the FSM; a slip request holds until an enabled cycle ends.
module eth_pcs_block_lock
  import eth_pcs_params::*;
#(
  parameter int N_SH_GOOD   = N_SH_GOOD_DEF,
  parameter int N_SH_BAD    = N_SH_BAD_DEF,
  parameter int N_SLIP_WAIT = N_SLIP_WAIT_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clk_en,
  input  logic              i_grbx_hdr_valid,
  input  logic [W_SYNC-1:0] i_grbx_hdr,
  output logic              o_grbx_slip,
  output logic              o_block_lock,
  output logic              o_dec_reset,
  output logic [15:0]       o_slip_cnt
);

  localparam int W_SH   = $clog2(N_SH_GOOD + 1);
  localparam int W_BAD  = $clog2(N_SH_BAD + 1);
  localparam int W_WAIT = $clog2(N_SLIP_WAIT + 1);

  lock_state_t       q_state, d_state;
  logic [W_SH-1:0]   q_sh_cnt, d_sh_cnt, sh_cnt_inc;
  logic [W_BAD-1:0]  q_sh_bad, d_sh_bad, sh_bad_inc;
  logic [W_WAIT-1:0] q_wait_cnt, d_wait_cnt, wait_cnt_inc;
  logic              q_lock, d_lock;
  logic              q_slip, d_slip;
  logic              q_block_lock, d_block_lock;
  logic [15:0]       q_slip_cnt, d_slip_cnt;
  logic              hev;

  always_comb begin
    d_state      = q_state;
    d_sh_cnt     = q_sh_cnt;
    d_sh_bad     = q_sh_bad;
    d_wait_cnt   = q_wait_cnt;
    d_lock       = q_lock;
    d_slip       = q_slip;
    d_block_lock = q_block_lock;
    d_slip_cnt   = q_slip_cnt;
    hev          = i_clk_en & i_grbx_hdr_valid;
    sh_cnt_inc   = q_sh_cnt + 1'b1;
    sh_bad_inc   = q_sh_bad + 1'b1;
    wait_cnt_inc = q_wait_cnt + 1'b1;

    // With the enable low everything freezes, including a pending slip request.
    if (i_clk_en) begin
      d_slip       = 1'b0;
      d_block_lock = q_lock;
      case (q_state)
        S_RESET_CNT: begin
          d_sh_cnt = '0;
          d_sh_bad = '0;
          d_state  = S_TEST;
        end
        S_TEST: begin
          if (hev) begin
            d_sh_cnt = sh_cnt_inc;
            if (sync_hdr_ok(i_grbx_hdr)) begin
              if (sh_cnt_inc == W_SH'(N_SH_GOOD)) begin
                if (q_sh_bad == '0) d_lock = 1'b1;
                d_state = S_RESET_CNT;
              end
            end else begin
              d_sh_bad = sh_bad_inc;
              // Bad-count threshold wins over a coincident window end.
              if (!q_lock || (sh_bad_inc == W_BAD'(N_SH_BAD))) d_state = S_SLIP;
              else if (sh_cnt_inc == W_SH'(N_SH_GOOD))         d_state = S_RESET_CNT;
            end
          end
        end
        S_SLIP: begin
          d_lock     = 1'b0;
          d_slip     = 1'b1;
          d_wait_cnt = '0;
          if (q_slip_cnt != 16'hFFFF) d_slip_cnt = q_slip_cnt + 16'd1;
          d_state    = S_WAIT;
        end
        S_WAIT: begin
          if (hev) begin
            d_wait_cnt = wait_cnt_inc;
            if (wait_cnt_inc == W_WAIT'(N_SLIP_WAIT)) d_state = S_RESET_CNT;
          end
        end
        default: d_state = S_RESET_CNT;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      q_state      <= S_RESET_CNT;
      q_sh_cnt     <= '0;
      q_sh_bad     <= '0;
      q_wait_cnt   <= '0;
      q_lock       <= 1'b0;
      q_slip       <= 1'b0;
      q_block_lock <= 1'b0;
      q_slip_cnt   <= '0;
    end else begin
      q_state      <= d_state;
      q_sh_cnt     <= d_sh_cnt;
      q_sh_bad     <= d_sh_bad;
      q_wait_cnt   <= d_wait_cnt;
      q_lock       <= d_lock;
      q_slip       <= d_slip;
      q_block_lock <= d_block_lock;
      q_slip_cnt   <= d_slip_cnt;
    end
  end

  assign o_grbx_slip  = q_slip;
  assign o_block_lock = q_block_lock;
  assign o_dec_reset  = ~q_block_lock;
  assign o_slip_cnt   = q_slip_cnt;

endmodule

// File: tb/tb_eth_pcs_block_lock.sv
// Bench for eth_pcs_block_lock: scenario tasks plus a randomized stream, all checked against a window/slip model.
module tb_eth_pcs_block_lock;

  localparam int N_SH_GOOD   = 64;
  localparam int N_SH_BAD    = 16;
  localparam int N_SLIP_WAIT = 2;

  logic        i_clk, i_reset, i_clk_en, i_grbx_hdr_valid;
  logic [1:0]  i_grbx_hdr;
  logic        o_grbx_slip, o_block_lock, o_dec_reset;
  logic [15:0] o_slip_cnt;
  logic [18:0] dut_vec;

  int n_vec = 0;
  int n_err = 0;

  eth_pcs_block_lock dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_clk_en         (i_clk_en),
    .i_grbx_hdr_valid (i_grbx_hdr_valid),
    .i_grbx_hdr       (i_grbx_hdr),
    .o_grbx_slip      (o_grbx_slip),
    .o_block_lock     (o_block_lock),
    .o_dec_reset      (o_dec_reset),
    .o_slip_cnt       (o_slip_cnt)
  );

  assign dut_vec = {o_grbx_slip, o_block_lock, o_dec_reset, o_slip_cnt};

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model: pending actions plus window tallies, stepped once per enabled cycle.
  bit          m_restart, m_slip_pend, m_lock, m_slip_o, m_lock_o;
  int          m_wait, m_seen, m_bad;
  logic [15:0] m_slips;
  bit          mask [64];

  task automatic m_reset();
    m_restart = 1; m_slip_pend = 0; m_lock = 0; m_slip_o = 0; m_lock_o = 0;
    m_wait = 0; m_seen = 0; m_bad = 0; m_slips = 16'h0;
  endtask

  task automatic m_step(input bit ce, input bit hev, input logic [1:0] hdr);
    bit good;
    if (!ce) return;
    good = (hdr == 2'b01) || (hdr == 2'b10);
    m_lock_o = m_lock;
    m_slip_o = 0;
    if (m_restart) begin
      m_seen = 0; m_bad = 0; m_restart = 0;
    end else if (m_slip_pend) begin
      m_slip_pend = 0; m_lock = 0; m_slip_o = 1; m_wait = N_SLIP_WAIT;
      if (m_slips != 16'hFFFF) m_slips = m_slips + 16'd1;
    end else if (m_wait > 0) begin
      if (hev) begin
        m_wait--;
        if (m_wait == 0) m_restart = 1;
      end
    end else if (hev) begin
      m_seen++;
      if (!good) begin
        m_bad++;
        if (!m_lock || m_bad == N_SH_BAD) m_slip_pend = 1;
        else if (m_seen == N_SH_GOOD)     m_restart = 1;
      end else if (m_seen == N_SH_GOOD) begin
        if (m_bad == 0) m_lock = 1;
        m_restart = 1;
      end
    end
  endtask

  function automatic logic [18:0] exp_vec();
    return {m_slip_o, m_lock_o, ~m_lock_o, m_slips};
  endfunction

  function automatic logic [1:0] rnd_good();
    return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] rnd_bad();
    return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
  endfunction

  // k ones scattered over the first n mask slots, the rest zero.
  task automatic make_mask(input int n, input int k);
    bit t;
    for (int i = 0; i < 64; i++) mask[i] = (i < k);
    for (int i = n - 1; i > 0; i--) begin
      int j = $urandom_range(0, i);
      t = mask[i]; mask[i] = mask[j]; mask[j] = t;
    end
  endtask

  // One clock: inputs applied after a falling edge, model stepped at the rising edge.
  task automatic cyc(input bit ce, input bit hv, input logic [1:0] hdr);
    i_clk_en = ce; i_grbx_hdr_valid = hv; i_grbx_hdr = hdr;
    @(posedge i_clk);
    m_step(ce, ce & hv, hdr);
    @(negedge i_clk);
  endtask

  task automatic gaps();
    repeat ($urandom_range(0, 2)) cyc(0, 1'($urandom), 2'($urandom));
  endtask

  task automatic do_reset();
    i_reset = 1; i_clk_en = 0; i_grbx_hdr_valid = 0; i_grbx_hdr = 2'b00;
    @(negedge i_clk); @(negedge i_clk);
    m_reset();
    i_reset = 0;
    cyc(1, 0, 2'b00);
  endtask

  task automatic get_lock();
    do_reset();
    repeat (N_SH_GOOD) cyc(1, 1, rnd_good());
    cyc(1, 0, 2'b00);
  endtask

  task automatic test_reset();
    i_reset = 1; i_clk_en = 0; i_grbx_hdr_valid = 0; i_grbx_hdr = 2'b00;
    @(negedge i_clk); @(negedge i_clk);
    n_vec++;
    if (dut_vec !== {1'b0, 1'b0, 1'b1, 16'h0}) begin
      n_err++; $display("FAIL reset_values got %h exp %h", dut_vec, {1'b0, 1'b0, 1'b1, 16'h0});
    end
  endtask

  task automatic test_acquire();
    do_reset();
    for (int i = 1; i <= N_SH_GOOD; i++) begin
      cyc(1, 1, rnd_good());
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL acquire_hev%0d got %h exp %h", i, dut_vec, exp_vec());
      end
    end
    n_vec++;
    if (o_block_lock !== 1'b0) begin n_err++; $display("FAIL acquire_early got %b exp 0", o_block_lock); end
    cyc(1, 0, 2'b00);
    n_vec++;
    if ({o_block_lock, o_dec_reset, o_grbx_slip} !== 3'b100) begin
      n_err++; $display("FAIL acquire_lock got %b exp 100", {o_block_lock, o_dec_reset, o_grbx_slip});
    end
  endtask

  task automatic test_slip_unlocked();
    int slips = 0;
    do_reset();
    for (int i = 1; i <= 14; i++) begin
      if (i <= 10)      cyc(1, 1, (i == 10) ? rnd_bad() : rnd_good());
      else if (i == 11) cyc(1, 0, 2'b00);
      else if (i <= 13) cyc(1, 1, rnd_bad());
      else              cyc(1, 0, 2'b00);
      if (o_grbx_slip) slips++;
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL slip_seq%0d got %h exp %h", i, dut_vec, exp_vec());
      end
    end
    n_vec++;
    if (slips != 1 || o_slip_cnt !== 16'd1) begin
      n_err++; $display("FAIL slip_once got pulses=%0d cnt=%0d exp 1/1", slips, o_slip_cnt);
    end
    repeat (N_SH_GOOD - 1) cyc(1, 1, rnd_good());
    n_vec++;
    if (o_block_lock !== 1'b0) begin n_err++; $display("FAIL relock_early got %b exp 0", o_block_lock); end
    cyc(1, 1, rnd_good());
    cyc(1, 0, 2'b00);
    n_vec++;
    if (o_block_lock !== 1'b1 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL relock got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_hysteresis();
    int slips = 0;
    int bads  = 0;
    get_lock();
    make_mask(64, N_SH_BAD - 1);
    for (int i = 0; i < 64; i++) begin
      gaps();
      cyc(1, 1, mask[i] ? rnd_bad() : rnd_good());
      n_vec++;
      if (dut_vec !== exp_vec() || o_block_lock !== 1'b1) begin
        n_err++; $display("FAIL hyst_hold%0d got %h exp %h", i, dut_vec, exp_vec());
      end
    end
    cyc(1, 0, 2'b00);
    make_mask(40, N_SH_BAD);
    for (int i = 0; i < 40 && bads < N_SH_BAD; i++) begin
      gaps();
      cyc(1, 1, mask[i] ? rnd_bad() : rnd_good());
      if (mask[i]) bads++;
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL hyst_drop%0d got %h exp %h", i, dut_vec, exp_vec());
      end
    end
    repeat (4) begin
      cyc(1, 0, 2'b00);
      if (o_grbx_slip) slips++;
    end
    n_vec++;
    if (slips != 1 || o_block_lock !== 1'b0 || o_dec_reset !== 1'b1 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL hyst_lost got pulses=%0d vec=%h exp 1 %h", slips, dut_vec, exp_vec());
    end
  endtask

  task automatic test_clk_en();
    do_reset();
    cyc(1, 1, rnd_bad());
    cyc(1, 0, 2'b00);
    n_vec++;
    if (o_grbx_slip !== 1'b1) begin n_err++; $display("FAIL ce_slip_rise got %b exp 1", o_grbx_slip); end
    repeat (3) begin
      cyc(0, 1, rnd_bad());
      n_vec++;
      if (o_grbx_slip !== 1'b1 || dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL ce_slip_hold got %h exp %h", dut_vec, exp_vec());
      end
    end
    cyc(1, 0, 2'b00);
    n_vec++;
    if (o_grbx_slip !== 1'b0) begin n_err++; $display("FAIL ce_slip_fall got %b exp 0", o_grbx_slip); end
    for (int i = 0; i < 9; i++) begin
      if (i < 2)      cyc(0, 1, rnd_bad());
      else if (i < 4) cyc(1, 1, rnd_bad());
      else if (i < 5) cyc(1, 0, 2'b00);
      else            cyc(1, 1, rnd_good());
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL ce_seq%0d got %h exp %h", i, dut_vec, exp_vec());
      end
    end
    n_vec++;
    if (o_slip_cnt !== 16'd1) begin n_err++; $display("FAIL ce_slip_cnt got %0d exp 1", o_slip_cnt); end
  endtask

  task automatic test_reset_mid();
    get_lock();
    repeat (40) cyc(1, 1, rnd_good());
    n_vec++;
    if (o_block_lock !== 1'b1) begin n_err++; $display("FAIL mid_locked got %b exp 1", o_block_lock); end
    #2 i_reset = 1;
    #1;
    n_vec++;
    if (dut_vec !== {1'b0, 1'b0, 1'b1, 16'h0}) begin
      n_err++; $display("FAIL mid_async got %h exp %h", dut_vec, {1'b0, 1'b0, 1'b1, 16'h0});
    end
    do_reset();
    cyc(1, 1, rnd_bad());
    cyc(1, 0, 2'b00);
    #2 i_reset = 1;
    #1;
    n_vec++;
    if (o_grbx_slip !== 1'b0 || o_slip_cnt !== 16'h0) begin
      n_err++; $display("FAIL mid_slip_cancel got slip=%b cnt=%0d exp 0/0", o_grbx_slip, o_slip_cnt);
    end
    do_reset();
    repeat (N_SH_GOOD - 1) cyc(1, 1, rnd_good());
    n_vec++;
    if (o_block_lock !== 1'b0) begin n_err++; $display("FAIL mid_relock_early got %b exp 0", o_block_lock); end
    cyc(1, 1, rnd_good());
    cyc(1, 0, 2'b00);
    n_vec++;
    if (o_block_lock !== 1'b1 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL mid_relock got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_boundary();
    get_lock();
    make_mask(63, N_SH_BAD - 1);
    mask[63] = 1;
    for (int i = 0; i < 64; i++) begin
      cyc(1, 1, mask[i] ? 2'b11 : rnd_good());
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL bound_hev%0d got %h exp %h", i, dut_vec, exp_vec());
      end
    end
    cyc(1, 0, 2'b00);
    n_vec++;
    if (o_grbx_slip !== 1'b1 || o_slip_cnt !== 16'd1) begin
      n_err++; $display("FAIL bound_slip got slip=%b cnt=%0d exp 1/1", o_grbx_slip, o_slip_cnt);
    end
    cyc(1, 1, rnd_good()); cyc(1, 1, rnd_good()); cyc(1, 0, 2'b00);
    force dut.q_slip_cnt = 16'hFFFE;
    #1 release dut.q_slip_cnt;
    m_slips = 16'hFFFE;
    repeat (2) begin
      cyc(1, 1, 2'b11); cyc(1, 0, 2'b00);
      cyc(1, 1, rnd_good()); cyc(1, 1, rnd_good()); cyc(1, 0, 2'b00);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL bound_sat_seq got %h exp %h", dut_vec, exp_vec());
      end
    end
    n_vec++;
    if (o_slip_cnt !== 16'hFFFF) begin n_err++; $display("FAIL bound_sat got %h exp ffff", o_slip_cnt); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int pct = (i < 1500) ? 1 : 4;
      bit ce  = ($urandom_range(0, 3) != 0);
      bit hv  = ($urandom_range(0, 4) != 0);
      cyc(ce, hv, ($urandom_range(0, 99) < pct) ? rnd_bad() : rnd_good());
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL random%0d got %h exp %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_slip_unlocked();
    test_hysteresis();
    test_clk_en();
    test_reset_mid();
    test_boundary();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
